regfile_sb: RTL

- Parametrised successor to the core's integer register file: two combinational read ports, one write port with load-extension modes, x0 hardwired to zero, and optional write-to-read bypass.
- Adds a sequential clear sweep (one entry per cycle, RAM-inferable) and a per-register busy scoreboard for outstanding loads.
- Sits in the decode/writeback boundary of the RISC-V pipeline; the hazard unit consumes busy1/busy2 and ready.

---
 rtl/rv_pkg.sv | 20 ++
 rtl/rf_load_ext.sv | 24 ++
 rtl/regfile_sb.sv | 122 ++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared write-mode and register-file state encodings
package rv_pkg;

    localparam logic [2:0] WM_NONE = 3'd0;
    localparam logic [2:0] WM_W    = 3'd1;
    localparam logic [2:0] WM_LB   = 3'd2;
    localparam logic [2:0] WM_LH   = 3'd3;
    localparam logic [2:0] WM_LBU  = 3'd4;
    localparam logic [2:0] WM_LHU  = 3'd5;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    function automatic logic wm_valid(input logic [2:0] mode);
        return (mode >= WM_W) && (mode <= WM_LHU);
    endfunction

endpackage

// File: rtl/rf_load_ext.sv
// rtl/rf_load_ext.sv - sign/zero extender for word, byte and halfword loads
module rf_load_ext
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] din,
    input  logic [2:0]      mode,
    output logic [XLEN-1:0] dout
);

    always_comb begin
        dout = '0;
        case (mode)
            WM_W:    dout = din;
            WM_LB:   dout = {{(XLEN-8){din[7]}}, din[7:0]};
            WM_LH:   dout = {{(XLEN-16){din[15]}}, din[15:0]};
            WM_LBU:  dout = {{(XLEN-8){1'b0}}, din[7:0]};
            WM_LHU:  dout = {{(XLEN-16){1'b0}}, din[15:0]};
            default: dout = '0;
        endcase
    end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - integer register file with clear sweep and load scoreboard
module regfile_sb
    import rv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    input  logic [AW-1:0]   A3,
    input  logic [XLEN-1:0] WD3,
    input  logic [2:0]      WE3,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    input  logic            busy_set,
    input  logic [AW-1:0]   busy_addr,
    output logic            busy1,
    output logic            busy2,
    input  logic            clr_req,
    output logic            ready
);

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [XLEN-1:0]   mem_q [NREGS];

    logic [XLEN-1:0]   ext;
    logic              wr_valid;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [XLEN-1:0]   mem_wdata;

    rf_load_ext #(.XLEN(XLEN)) u_ext (
        .din  (WD3),
        .mode (WE3),
        .dout (ext)
    );

    assign wr_valid = (state_q == ST_IDLE) && wm_valid(WE3) && (A3 != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(NREGS - 1)) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    busy_d  = '0;
                end else begin
                    if (wr_valid)
                        busy_d[A3] = 1'b0;
                    // a newly issued load outranks the writeback of the previous one
                    if (busy_set && (busy_addr != '0))
                        busy_d[busy_addr] = 1'b1;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // single write port shared by the sweep and normal writeback keeps the array RAM-shaped
    always_comb begin
        mem_we    = (state_q == ST_CLEAR) || wr_valid;
        mem_waddr = (state_q == ST_CLEAR) ? cnt_q : A3;
        mem_wdata = (state_q == ST_CLEAR) ? '0 : ext;
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem_q[mem_waddr] <= mem_wdata;
    end

    always_comb begin
        RD1 = mem_q[A1];
        RD2 = mem_q[A2];
        if ((BYPASS != 0) && wr_valid && (A3 == A1))
            RD1 = ext;
        if ((BYPASS != 0) && wr_valid && (A3 == A2))
            RD2 = ext;
        if ((state_q != ST_IDLE) || (A1 == '0))
            RD1 = '0;
        if ((state_q != ST_IDLE) || (A2 == '0))
            RD2 = '0;
    end

    assign busy1 = busy_q[A1];
    assign busy2 = busy_q[A2];
    assign ready = ready_q;

endmodule
